sdcard_spi_engine: RTL and testbench

- Parametrised SPI-mode bit/byte engine for SD cards; successor to the fixed-divider SD function module.
- Runs two transaction types:
  - single-byte full-duplex transfers;
  - complete 6-byte command frames with response polling, timeout and multi-byte response capture (R1/R3/R7).
- Clock speed is a per-transaction input, not decoded from the command byte.
- Sits between the SD control FSM (init/read/write sequencers) and the card pins.

---
 rtl/sdcard_spi_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_sdcard_spi_engine.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdcard_spi_engine.sv
// SPI-mode SD card engine: single-byte transfers and 6-byte command frames with R1 polling, timeout and response capture.
// Optional macro SDSPI_CRC7_EN replaces command byte 5 with the serially computed {crc7, 1'b1}.
module sdcard_spi_engine #(
  parameter int LOW_DIV      = 500,
  parameter int HIGH_DIV     = 6,
  parameter int RESP_TIMEOUT = 100,
  parameter int RESP_MAX     = 5
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  SD_DOUT,
  output logic                  SD_CLK,
  output logic                  SD_DI,
  output logic                  SD_NCS,
  input  logic                  iCS,
  input  logic [1:0]            iCall,
  input  logic                  iSpeed,
  input  logic [47:0]           iCmd,
  input  logic [2:0]            iRespLen,
  input  logic [7:0]            iData,
  output logic                  oDone,
  output logic [7:0]            oData,
  output logic [8*RESP_MAX-1:0] oResp,
  output logic                  oTimeout
);

  localparam logic [15:0] LP_LOW  = 16'(LOW_DIV);
  localparam logic [15:0] LP_HIGH = 16'(HIGH_DIV);
  localparam logic [15:0] LP_TO   = 16'(RESP_TIMEOUT - 1);
  localparam logic [2:0]  LP_RMAX = 3'(RESP_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_POLL, S_RESP, S_DONE} state_t;

  state_t      r_state;
  logic        r_cmd_mode;
  logic        r_hold;
  logic [15:0] r_div;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [2:0]  r_idx;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic [39:0] r_frame;
  logic [2:0]  r_len;
  logic [2:0]  r_ridx;
  logic [15:0] r_poll;
`ifdef SDSPI_CRC7_EN
  logic [6:0]  r_crc;

  function automatic logic [6:0] f_crc7(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction
`endif

  logic       w_half;
  logic       w_end;
  logic       w_byte_end;
  logic [2:0] w_len;
  logic [2:0] w_next_idx;
  logic [7:0] w_next_tx;

  assign w_half     = (r_cnt == (r_div >> 1));
  assign w_end      = (r_cnt == (r_div - 16'd1));
  assign w_byte_end = w_end && (r_bit == 3'd7);

  always_comb begin
    w_len = iRespLen;
    if (iRespLen == 3'd0)
      w_len = 3'd1;
    else if (iRespLen > LP_RMAX)
      w_len = LP_RMAX;
  end

  // Next command byte to shift out once the current one completes
  always_comb begin
    w_next_idx = r_idx + 3'd1;
    case (w_next_idx)
      3'd1:    w_next_tx = r_frame[39:32];
      3'd2:    w_next_tx = r_frame[31:24];
      3'd3:    w_next_tx = r_frame[23:16];
      3'd4:    w_next_tx = r_frame[15:8];
      3'd5:    w_next_tx = r_frame[7:0];
      default: w_next_tx = 8'hFF;
    endcase
`ifdef SDSPI_CRC7_EN
    if (w_next_idx == 3'd5)
      w_next_tx = {r_crc, 1'b1};
`endif
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)
      SD_NCS <= 1'b1;
    else
      SD_NCS <= ~iCS;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_cmd_mode <= 1'b0;
      r_hold     <= 1'b0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_frame    <= '0;
      r_len      <= '0;
      r_ridx     <= '0;
      r_poll     <= '0;
`ifdef SDSPI_CRC7_EN
      r_crc      <= '0;
`endif
      SD_CLK     <= 1'b1;
      SD_DI      <= 1'b1;
      oDone      <= 1'b0;
      oData      <= 8'h00;
      oResp      <= '1;
      oTimeout   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          SD_CLK <= 1'b1;
          SD_DI  <= 1'b1;
          // r_hold blocks re-launch until the caller releases iCall
          if (iCall == 2'b00) begin
            r_hold <= 1'b0;
          end else if (!r_hold) begin
            r_div   <= iSpeed ? LP_HIGH : LP_LOW;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_idx   <= '0;
            r_state <= S_SEND;
            if (iCall[1]) begin
              r_cmd_mode <= 1'b1;
              r_frame    <= iCmd[39:0];
              r_tx       <= iCmd[47:40];
              r_len      <= w_len;
              oTimeout   <= 1'b0;
`ifdef SDSPI_CRC7_EN
              r_crc      <= '0;
`endif
            end else begin
              r_cmd_mode <= 1'b0;
              r_tx       <= iData;
            end
          end
        end

        S_SEND, S_POLL, S_RESP: begin
          if (iCall == 2'b00) begin
            r_state <= S_IDLE;
            SD_CLK  <= 1'b1;
            SD_DI   <= 1'b1;
          end else begin
            if (r_cnt == 16'd0) begin
              SD_CLK <= 1'b0;
              SD_DI  <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b1};
`ifdef SDSPI_CRC7_EN
              if (r_state == S_SEND && r_cmd_mode && r_idx != 3'd5)
                r_crc <= f_crc7(r_crc, r_tx[7]);
`endif
            end
            if (w_half) begin
              SD_CLK <= 1'b1;
              r_rx   <= {r_rx[6:0], SD_DOUT};
            end
            if (w_end) begin
              r_cnt <= '0;
              r_bit <= r_bit + 3'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end

            if (w_byte_end) begin
              oData <= r_rx;
              case (r_state)
                S_SEND: begin
                  if (!r_cmd_mode) begin
                    r_state <= S_DONE;
                  end else if (r_idx == 3'd5) begin
                    r_state <= S_POLL;
                    r_poll  <= '0;
                    r_tx    <= 8'hFF;
                  end else begin
                    r_idx <= w_next_idx;
                    r_tx  <= w_next_tx;
                  end
                end
                S_POLL: begin
                  r_tx <= 8'hFF;
                  if (r_rx != 8'hFF) begin
                    oResp <= '1;
                    oResp[8*RESP_MAX-1 -: 8] <= r_rx;
                    r_ridx <= 3'd1;
                    r_state <= (r_len > 3'd1) ? S_RESP : S_DONE;
                  end else if (r_poll == LP_TO) begin
                    oTimeout <= 1'b1;
                    oResp    <= '1;
                    r_state  <= S_DONE;
                  end else begin
                    r_poll <= r_poll + 16'd1;
                  end
                end
                default: begin
                  r_tx <= 8'hFF;
                  oResp[8*(RESP_MAX-1-int'(r_ridx)) +: 8] <= r_rx;
                  if (r_ridx == r_len - 3'd1)
                    r_state <= S_DONE;
                  else
                    r_ridx <= r_ridx + 3'd1;
                end
              endcase
            end
          end
        end

        S_DONE: begin
          oDone   <= 1'b1;
          r_hold  <= 1'b1;
          SD_CLK  <= 1'b1;
          SD_DI   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcard_spi_engine.sv
// Directed bench for sdcard_spi_engine: byte transfers, command frames, timeout, abort and reset.
module tb_sdcard_spi_engine;

  localparam int LOW_DIV      = 10;
  localparam int HIGH_DIV     = 6;
  localparam int RESP_TIMEOUT = 100;
  localparam int RESP_MAX     = 5;

  logic                  CLOCK = 1'b0;
  logic                  RESET = 1'b1;
  logic                  SD_DOUT = 1'b1;
  logic                  SD_CLK;
  logic                  SD_DI;
  logic                  SD_NCS;
  logic                  iCS = 1'b0;
  logic [1:0]            iCall = 2'b00;
  logic                  iSpeed = 1'b0;
  logic [47:0]           iCmd = '0;
  logic [2:0]            iRespLen = '0;
  logic [7:0]            iData = '0;
  logic                  oDone;
  logic [7:0]            oData;
  logic [8*RESP_MAX-1:0] oResp;
  logic                  oTimeout;

  sdcard_spi_engine #(
    .LOW_DIV(LOW_DIV), .HIGH_DIV(HIGH_DIV),
    .RESP_TIMEOUT(RESP_TIMEOUT), .RESP_MAX(RESP_MAX)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .SD_DOUT(SD_DOUT),
    .SD_CLK(SD_CLK), .SD_DI(SD_DI), .SD_NCS(SD_NCS),
    .iCS(iCS), .iCall(iCall), .iSpeed(iSpeed), .iCmd(iCmd),
    .iRespLen(iRespLen), .iData(iData),
    .oDone(oDone), .oData(oData), .oResp(oResp), .oTimeout(oTimeout)
  );

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Card model: streams card_bytes (then 0xFF) MSB first, shifting on SD_CLK falling edges
  logic [7:0] card_bytes [0:15];
  int         card_len = 0;
  int         card_gen = 0;
  int         card_seen = 0;
  int         card_pos = 0;
  logic [7:0] card_cur;

  always @(negedge SD_CLK) begin
    if (card_seen != card_gen) begin
      card_seen = card_gen;
      card_pos  = 0;
    end
    card_cur = ((card_pos / 8) < card_len) ? card_bytes[card_pos / 8] : 8'hFF;
    SD_DOUT  = card_cur[7 - (card_pos % 8)];
    card_pos++;
  end

  // MOSI capture on SD_CLK rising edges
  logic [7:0] mosi_bytes [0:15];
  logic [7:0] mosi_sr = 8'h00;
  int         mosi_seen = 0;
  int         mosi_pos = 0;

  always @(posedge SD_CLK) begin
    if (mosi_seen != card_gen) begin
      mosi_seen = card_gen;
      mosi_pos  = 0;
    end
    mosi_sr = {mosi_sr[6:0], SD_DI};
    mosi_pos++;
    if ((mosi_pos % 8) == 0 && (mosi_pos / 8) <= 16)
      mosi_bytes[mosi_pos / 8 - 1] = mosi_sr;
  end

  task automatic card_load(input logic [127:0] bytes, input int n);
    for (int i = 0; i < n; i++)
      card_bytes[i] = bytes[8*(n-1-i) +: 8];
    card_len = n;
    card_gen++;
  endtask

  task automatic run(input logic [1:0] call, input logic spd, input logic [47:0] cmd,
                     input logic [2:0] len, input logic [7:0] d, input int maxc,
                     output int lat);
    @(posedge CLOCK); #1;
    iCall = call; iSpeed = spd; iCmd = cmd; iRespLen = len; iData = d;
    lat = 0;
    while (lat < maxc) begin
      @(posedge CLOCK); #1;
      lat++;
      if (oDone) break;
    end
  endtask

  task automatic finish_txn(input string tag);
    @(posedge CLOCK); #1;
    check_eq(tag, 64'(oDone), 64'd0);
    iCall = 2'b00;
    @(posedge CLOCK); #1;
  endtask

  int         lat;
  int         bad;
  logic [7:0] prev_data;
  logic [7:0] exp_b5;

  initial begin
    repeat (3) @(posedge CLOCK);
    #1;
    check_eq("rst_sdclk",   64'(SD_CLK),   64'd1);
    check_eq("rst_sddi",    64'(SD_DI),    64'd1);
    check_eq("rst_ncs",     64'(SD_NCS),   64'd1);
    check_eq("rst_done",    64'(oDone),    64'd0);
    check_eq("rst_odata",   64'(oData),    64'h00);
    check_eq("rst_oresp",   64'(oResp),    64'hFF_FFFF_FFFF);
    check_eq("rst_timeout", 64'(oTimeout), 64'd0);
    RESET = 1'b0;

    iCS = 1'b1;
    @(posedge CLOCK); #1;
    check_eq("ncs_follow", 64'(SD_NCS), 64'd0);

    // High-speed byte transfer
    card_load(128'h3C, 1);
    run(2'b01, 1'b1, 48'h0, 3'd0, 8'hA5, 200, lat);
    check_eq("byte_hs_lat",  64'(lat),           64'd50);
    check_eq("byte_hs_data", 64'(oData),         64'h3C);
    check_eq("byte_hs_mosi", 64'(mosi_bytes[0]), 64'hA5);
    @(posedge CLOCK); #1;
    check_eq("byte_hs_pulse", 64'(oDone), 64'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLOCK); #1;
      if (oDone || !SD_CLK) bad++;
    end
    check_eq("no_relaunch", 64'(bad), 64'd0);
    iCall = 2'b00;
    @(posedge CLOCK); #1;

    // Low-speed byte transfer
    card_load(128'hC3, 1);
    run(2'b01, 1'b0, 48'h0, 3'd0, 8'h5A, 400, lat);
    check_eq("byte_ls_lat",  64'(lat),           64'd82);
    check_eq("byte_ls_data", 64'(oData),         64'hC3);
    check_eq("byte_ls_mosi", 64'(mosi_bytes[0]), 64'h5A);
    finish_txn("byte_ls_pulse");

    // CMD0, R1 = 0x01 after two idle poll bytes
    card_load(128'hFFFFFFFFFFFFFFFF01, 9);
    run(2'b10, 1'b1, 48'h400000000095, 3'd1, 8'h00, 2000, lat);
    check_eq("cmd0_lat",     64'(lat),      64'd434);
    check_eq("cmd0_resp",    64'(oResp),    64'h01_FFFF_FFFF);
    check_eq("cmd0_timeout", 64'(oTimeout), 64'd0);
    check_eq("cmd0_odata",   64'(oData),    64'h01);
    check_eq("cmd0_mosi", 64'({mosi_bytes[0], mosi_bytes[1], mosi_bytes[2],
                                mosi_bytes[3], mosi_bytes[4], mosi_bytes[5]}),
             64'h400000000095);
    finish_txn("cmd0_pulse");

    // CMD8 with 5-byte R7 response; iCall=11 must behave as a command
    card_load(128'hFFFFFFFFFFFFFF01000001AA, 12);
    run(2'b11, 1'b1, 48'h48000001AA87, 3'd5, 8'h00, 2000, lat);
    check_eq("cmd8_lat",   64'(lat),   64'd578);
    check_eq("cmd8_resp",  64'(oResp), 64'h01_0000_01AA);
    check_eq("cmd8_odata", 64'(oData), 64'hAA);
    finish_txn("cmd8_pulse");

    // Card never answers
    card_load(128'h0, 0);
    run(2'b10, 1'b1, 48'h7700000000FF, 3'd1, 8'h00, 6000, lat);
    check_eq("to_lat",     64'(lat),      64'd5090);
    check_eq("to_flag",    64'(oTimeout), 64'd1);
    check_eq("to_resp",    64'(oResp),    64'hFF_FFFF_FFFF);
    finish_txn("to_pulse");

    // Byte 5 is either the computed CRC or iCmd[7:0] verbatim
`ifdef SDSPI_CRC7_EN
    exp_b5 = 8'h95;
`else
    exp_b5 = 8'h00;
`endif
    card_load(128'hFFFFFFFFFFFF00, 7);
    run(2'b10, 1'b1, 48'h400000000000, 3'd0, 8'h00, 2000, lat);
    check_eq("crc_byte5",   64'(mosi_bytes[5]), 64'(exp_b5));
    check_eq("crc_timeout", 64'(oTimeout),      64'd0);
    check_eq("crc_resp",    64'(oResp),         64'h00_FFFF_FFFF);
    finish_txn("crc_pulse");

    // Abort by dropping iCall mid-byte
    prev_data = oData;
    card_load(128'h81, 1);
    @(posedge CLOCK); #1;
    iCall = 2'b01; iSpeed = 1'b1; iData = 8'h00;
    repeat (20) @(posedge CLOCK);
    #1;
    check_eq("abort_pre_clk", 64'(SD_CLK), 64'd0);
    iCall = 2'b00;
    @(posedge CLOCK); #1;
    check_eq("abort_sdclk", 64'(SD_CLK), 64'd1);
    check_eq("abort_sddi",  64'(SD_DI),  64'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLOCK); #1;
      if (oDone || !SD_CLK) bad++;
    end
    check_eq("abort_quiet", 64'(bad),   64'd0);
    check_eq("abort_odata", 64'(oData), 64'(prev_data));

    // Asynchronous reset in the middle of a command
    card_load(128'h0, 0);
    @(posedge CLOCK); #1;
    iCall = 2'b10; iCmd = 48'h400000000095; iRespLen = 3'd1;
    repeat (100) @(posedge CLOCK);
    #1;
    check_eq("mid_cmd_active", 64'(oResp), 64'h00_FFFF_FFFF);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("arst_sdclk",   64'(SD_CLK),   64'd1);
    check_eq("arst_sddi",    64'(SD_DI),    64'd1);
    check_eq("arst_ncs",     64'(SD_NCS),   64'd1);
    check_eq("arst_done",    64'(oDone),    64'd0);
    check_eq("arst_odata",   64'(oData),    64'h00);
    check_eq("arst_oresp",   64'(oResp),    64'hFF_FFFF_FFFF);
    check_eq("arst_timeout", 64'(oTimeout), 64'd0);
    iCall = 2'b00;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(posedge CLOCK); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
